// File: rtl/lsu_pkg.sv
// Load/store unit package: controller state encoding and access-size codes.
`ifndef LSU_DEFINES_SV
`include "defines.sv"
`endif
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DRAIN,
    ST_DONE
  } lsu_state_e;

  localparam logic [2:0] SIZE_B  = `LSU_SIZE_B;
  localparam logic [2:0] SIZE_H  = `LSU_SIZE_H;
  localparam logic [2:0] SIZE_W  = `LSU_SIZE_W;
  localparam logic [2:0] SIZE_BU = `LSU_SIZE_BU;
  localparam logic [2:0] SIZE_HU = `LSU_SIZE_HU;

endpackage

// File: rtl/defines.sv
// LSU funct3 access-size codes shared by the memory-stage logic.
`ifndef LSU_DEFINES_SV
`define LSU_DEFINES_SV
`define LSU_SIZE_B  3'b000
`define LSU_SIZE_H  3'b001
`define LSU_SIZE_W  3'b010
`define LSU_SIZE_BU 3'b100
`define LSU_SIZE_HU 3'b101
`endif

// File: rtl/lsu_align.sv
// Combinational lane logic shared by store and load paths.
//   size, addr_lo   : funct3 size code and byte offset within the word
//   wdata_in        : raw store data -> wdata_out lane-replicated, be mask
//   rdata_in        : raw memory word -> rdata_out aligned and extended
//   misalign        : access crosses its natural alignment
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      size,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata_in,
  input  logic [XLEN-1:0] rdata_in,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_out,
  output logic [XLEN-1:0] rdata_out,
  output logic            misalign
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_in >> {addr_lo, 3'b000};

  always_comb begin
    be        = 4'b1111;
    wdata_out = wdata_in;
    rdata_out = shifted;
    misalign  = 1'b0;
    case (size)
      SIZE_B, SIZE_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {{(XLEN-8){shifted[7] & (size == SIZE_B)}}, shifted[7:0]};
      end
      SIZE_H, SIZE_HU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_out = {2{wdata_in[15:0]}};
        rdata_out = {{(XLEN-16){shifted[15] & (size == SIZE_H)}}, shifted[15:0]};
        misalign  = addr_lo[0];
      end
      SIZE_W: begin
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        misalign = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Memory-stage load/store controller: one decoded op -> one valid/ready
// data-memory transaction, stalling the pipeline until it completes.
//   ex_*            : decoded memory op from the execute/memory stage
//   flush           : kill the in-flight op
//   lsu_stall       : hold pipeline (combinational)
//   lsu_done/rdata/misalign : registered completion results
//   dmem_*          : registered request channel, response in
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_mem_we,
  input  logic            ex_mem_re,
  input  logic [2:0]      ex_size,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic            flush,
  output logic            lsu_stall,
  output logic            lsu_done,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_misalign,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_state_e state_q, state_d;
  logic [2:0] size_q;
  logic [1:0] lo_q;
  logic       store_q;
  logic       accept;

  logic [2:0]      al_size;
  logic [1:0]      al_lo;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_rdata;
  logic            al_misalign;

  assign accept = ex_valid & (ex_mem_we | ex_mem_re) & ~flush;

  // One aligner serves both paths: live inputs while IDLE (store formatting
  // and misalign decode), captured size/offset afterwards (load extension).
  assign al_size = (state_q == ST_IDLE) ? ex_size      : size_q;
  assign al_lo   = (state_q == ST_IDLE) ? ex_addr[1:0] : lo_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .size      (al_size),
    .addr_lo   (al_lo),
    .wdata_in  (ex_wdata),
    .rdata_in  (dmem_rdata),
    .be        (al_be),
    .wdata_out (al_wdata),
    .rdata_out (al_rdata),
    .misalign  (al_misalign)
  );

  always_comb begin
    state_d   = state_q;
    lsu_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          lsu_stall = 1'b1;
          state_d   = al_misalign ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        lsu_stall = 1'b1;
        // A flush coinciding with the handshake cannot recall the request:
        // the write has happened / the response is still owed.
        if (dmem_req_ready) begin
          if (store_q) state_d = flush ? ST_IDLE  : ST_DONE;
          else         state_d = flush ? ST_DRAIN : ST_RESP;
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        lsu_stall = 1'b1;
        if (flush)               state_d = dmem_rsp_valid ? ST_IDLE : ST_DRAIN;
        else if (dmem_rsp_valid) state_d = ST_DONE;
      end
      ST_DRAIN: begin
        lsu_stall = 1'b1;
        if (dmem_rsp_valid) state_d = ST_IDLE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      size_q         <= '0;
      lo_q           <= '0;
      store_q        <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_addr      <= '0;
      dmem_we        <= 1'b0;
      dmem_be        <= '0;
      dmem_wdata     <= '0;
      lsu_done       <= 1'b0;
      lsu_misalign   <= 1'b0;
      lsu_rdata      <= '0;
    end else begin
      state_q        <= state_d;
      dmem_req_valid <= (state_d == ST_REQ);
      lsu_done       <= (state_d == ST_DONE);
      lsu_misalign   <= (state_q == ST_IDLE) && (state_d == ST_DONE);
      if ((state_q == ST_IDLE) && accept) begin
        size_q  <= ex_size;
        lo_q    <= ex_addr[1:0];
        store_q <= ex_mem_we;
        if (!al_misalign) begin
          dmem_addr  <= {ex_addr[XLEN-1:2], 2'b00};
          dmem_we    <= ex_mem_we;
          dmem_be    <= al_be;
          dmem_wdata <= al_wdata;
        end
      end
      if ((state_q == ST_RESP) && dmem_rsp_valid && !flush) begin
        lsu_rdata <= al_rdata;
      end
    end
  end

endmodule
